// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction width, PC increment, NOP encoding
// and the fetch-stage state type.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] PC_INC = 32'd4;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (jr > jump > branch > sequential) plus a legality check
// of the selected address against the instruction-memory range.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 100
) (
  input  logic [INSTR_W-1:0] pc,
  input  logic [3:0]         pc_plus4_hi,
  input  logic               jr,
  input  logic [INSTR_W-1:0] jr_target,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               branch_taken,
  input  logic [INSTR_W-1:0] branch_target,
  output logic [INSTR_W-1:0] next_pc,
  output logic               redirect,
  output logic               illegal
);

  localparam logic [INSTR_W-1:0] PcLimit = INSTR_W'(4 * IMEM_WORDS);

  always_comb begin
    next_pc  = pc + PC_INC;
    redirect = 1'b1;
    if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      // Region bits come from the delay-slot PC, i.e. the jump's own PC+4.
      next_pc = {pc_plus4_hi, jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else begin
      redirect = 1'b0;
    end
  end

  assign illegal = (next_pc[1:0] != 2'b00) || (next_pc >= PcLimit);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, fetch counter
// and a RUN/HALT FSM that stops fetching on the first illegal next PC.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                branch_taken,
  input  logic [INSTR_W-1:0]  branch_target,
  input  logic                jump,
  input  logic [25:0]         jump_index,
  input  logic                jr,
  input  logic [INSTR_W-1:0]  jr_target,
  output logic [INSTR_W-1:0]  pc_out,
  input  logic [INSTR_W-1:0]  instr_in,
  output logic [INSTR_W-1:0]  if_id_instr,
  output logic [INSTR_W-1:0]  if_id_pc_plus4,
  output logic                if_id_valid,
  output logic                fault,
  output logic [31:0]         fetch_count
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic               fault_q, fault_d;
  logic [31:0]        cnt_q, cnt_d;

  logic [INSTR_W-1:0] next_pc;
  logic               redirect;
  logic               illegal;
  logic               pc_load;

  pc_next_sel #(
    .IMEM_WORDS (IMEM_WORDS)
  ) u_pc_next_sel (
    .pc            (pc_q),
    .pc_plus4_hi   (pc4_q[31:28]),
    .jr            (jr),
    .jr_target     (jr_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .illegal       (illegal)
  );

  // A redirect wins over stall; otherwise stall freezes the PC.
  assign pc_load = redirect || !stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FETCH_RUN: begin
        if (pc_load && illegal) begin
          fault_d = 1'b1;
          state_d = FETCH_HALT;
          instr_d = NOP;
          valid_d = 1'b0;
        end else begin
          if (pc_load) pc_d = next_pc;
          if (redirect || flush) begin
            instr_d = NOP;
            valid_d = 1'b0;
          end else if (!stall) begin
            instr_d = instr_in;
            pc4_d   = pc_q + PC_INC;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
          end
        end
      end
      FETCH_HALT: begin
        instr_d = NOP;
        valid_d = 1'b0;
      end
      default: state_d = FETCH_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_out         = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;
  assign fault          = fault_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an address-tagged instruction memory model:
// the word at byte address A reads as 32'hA000_0000 | A.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, branch_taken, jump, jr;
  logic [31:0] branch_target, jr_target;
  logic [25:0] jump_index;
  logic [31:0] pc_out, instr_in, if_id_instr, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign instr_in = (pc_out < 32'd400) ? (32'hA000_0000 | pc_out) : 32'hDEAD_BEEF;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_index     (jump_index),
    .jr             (jr),
    .jr_target      (jr_target),
    .pc_out         (pc_out),
    .instr_in       (instr_in),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [25:0] jidx;
    logic        jr;
    logic [31:0] jr_tgt;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; branch_taken = 0; jump = 0; jr = 0;
    branch_target = '0; jr_target = '0; jump_index = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " pc"}, pc_out, 32'h0);
    check({tag, " instr"}, if_id_instr, 32'h0);
    check({tag, " pc4"}, if_id_pc_plus4, 32'h0);
    check({tag, " valid"}, {31'd0, if_id_valid}, 32'd0);
    check({tag, " fault"}, {31'd0, fault}, 32'd0);
    check({tag, " cnt"}, fetch_count, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    //            stl fl br tgt     jmp jidx    jr jr_tgt   pc      instr           pc4     v cnt
    vecs[0]  = '{0, 0, 0, 32'h0,  0, 26'h0,   0, 32'h0,  32'h04, 32'hA000_0000, 32'h04, 1, 1};
    vecs[1]  = '{0, 0, 0, 32'h0,  0, 26'h0,   0, 32'h0,  32'h08, 32'hA000_0004, 32'h08, 1, 2};
    vecs[2]  = '{1, 0, 0, 32'h0,  0, 26'h0,   0, 32'h0,  32'h08, 32'hA000_0004, 32'h08, 1, 2};
    vecs[3]  = '{1, 0, 0, 32'h0,  0, 26'h0,   0, 32'h0,  32'h08, 32'hA000_0004, 32'h08, 1, 2};
    vecs[4]  = '{0, 0, 0, 32'h0,  0, 26'h0,   0, 32'h0,  32'h0C, 32'hA000_0008, 32'h0C, 1, 3};
    vecs[5]  = '{0, 0, 1, 32'h40, 0, 26'h0,   0, 32'h0,  32'h40, 32'h0,         32'h0C, 0, 3};
    vecs[6]  = '{0, 0, 0, 32'h0,  0, 26'h0,   0, 32'h0,  32'h44, 32'hA000_0040, 32'h44, 1, 4};
    vecs[7]  = '{0, 0, 0, 32'h0,  1, 26'h5,   0, 32'h0,  32'h14, 32'h0,         32'h44, 0, 4};
    vecs[8]  = '{0, 0, 0, 32'h0,  0, 26'h0,   0, 32'h0,  32'h18, 32'hA000_0014, 32'h18, 1, 5};
    vecs[9]  = '{0, 1, 0, 32'h0,  0, 26'h0,   0, 32'h0,  32'h1C, 32'h0,         32'h18, 0, 5};
    vecs[10] = '{0, 0, 0, 32'h0,  0, 26'h0,   0, 32'h0,  32'h20, 32'hA000_001C, 32'h20, 1, 6};
    vecs[11] = '{1, 0, 1, 32'h80, 0, 26'h0,   1, 32'h20, 32'h20, 32'h0,         32'h20, 0, 6};
    vecs[12] = '{1, 1, 0, 32'h0,  0, 26'h0,   0, 32'h0,  32'h20, 32'h0,         32'h20, 0, 6};
    vecs[13] = '{0, 0, 0, 32'h0,  0, 26'h0,   0, 32'h0,  32'h24, 32'hA000_0020, 32'h24, 1, 7};
    vecs[14] = '{0, 0, 0, 32'h0,  1, 26'h100, 1, 32'h30, 32'h30, 32'h0,         32'h24, 0, 7};
    vecs[15] = '{0, 0, 0, 32'h0,  0, 26'h0,   0, 32'h0,  32'h34, 32'hA000_0030, 32'h34, 1, 8};
    vecs[16] = '{1, 0, 1, 32'h10, 0, 26'h0,   0, 32'h0,  32'h10, 32'h0,         32'h34, 0, 8};
    vecs[17] = '{0, 0, 0, 32'h0,  0, 26'h0,   0, 32'h0,  32'h14, 32'hA000_0010, 32'h14, 1, 9};

    #2;
    check_reset_vals("reset");
    do_reset();
    check_reset_vals("release");

    for (int i = 0; i < 18; i++) begin
      stall = vecs[i].stall; flush = vecs[i].flush;
      branch_taken = vecs[i].br; branch_target = vecs[i].br_tgt;
      jump = vecs[i].jmp; jump_index = vecs[i].jidx;
      jr = vecs[i].jr; jr_target = vecs[i].jr_tgt;
      @(posedge clk);
      #1;
      check($sformatf("v%0d pc", i), pc_out, vecs[i].e_pc);
      check($sformatf("v%0d instr", i), if_id_instr, vecs[i].e_instr);
      check($sformatf("v%0d pc4", i), if_id_pc_plus4, vecs[i].e_pc4);
      check($sformatf("v%0d valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d cnt", i), fetch_count, vecs[i].e_cnt);
      check($sformatf("v%0d fault", i), {31'd0, fault}, 32'd0);
    end

    // Misaligned jr target: fault, PC keeps 0x14, then frozen while inputs toggle.
    idle_inputs();
    jr = 1; jr_target = 32'h22;
    @(posedge clk);
    #1;
    check("jrfault fault", {31'd0, fault}, 32'd1);
    check("jrfault pc", pc_out, 32'h14);
    check("jrfault valid", {31'd0, if_id_valid}, 32'd0);
    check("jrfault instr", if_id_instr, 32'h0);
    check("jrfault cnt", fetch_count, 32'd9);
    jr = 0; branch_taken = 1; branch_target = 32'h40;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("halt%0d pc", c), pc_out, 32'h14);
      check($sformatf("halt%0d cnt", c), fetch_count, 32'd9);
      check($sformatf("halt%0d valid", c), {31'd0, if_id_valid}, 32'd0);
      check($sformatf("halt%0d fault", c), {31'd0, fault}, 32'd1);
    end

    // Asynchronous reset mid-cycle while halted clears fault immediately.
    idle_inputs();
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check_reset_vals("halt async rst");
    @(negedge clk);
    rst = 0;

    // Run to PC=0x1C, stall, then async reset mid-cycle.
    repeat (7) @(posedge clk);
    #1;
    check("pre-rst pc", pc_out, 32'h1C);
    check("pre-rst cnt", fetch_count, 32'd7);
    stall = 1;
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check_reset_vals("stall async rst");
    @(negedge clk);
    rst = 0;
    stall = 0;

    // Sequential fetch up to the last word, stall there, then run off the end.
    repeat (99) @(posedge clk);
    #1;
    check("end pc", pc_out, 32'd396);
    check("end instr", if_id_instr, 32'hA000_0188);
    check("end cnt", fetch_count, 32'd99);
    stall = 1;
    @(posedge clk);
    #1;
    check("end stall fault", {31'd0, fault}, 32'd0);
    check("end stall pc", pc_out, 32'd396);
    stall = 0;
    @(posedge clk);
    #1;
    check("oob fault", {31'd0, fault}, 32'd1);
    check("oob pc", pc_out, 32'd396);
    check("oob valid", {31'd0, if_id_valid}, 32'd0);
    check("oob cnt", fetch_count, 32'd99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
